// File: rtl/button_reader.sv
// Eight-button debouncer feeding a first-word-fall-through event FIFO.
// Define BUTTON_RELEASE_EVT_EN to queue release events as well as presses.
module button_reader #(
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] btn_n,
  output logic [7:0] pressed,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [3:0] evt_data,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    sync1_reg;
  logic [7:0]    sync2_reg;
  logic [7:0]    sample;
  logic [15:0]   presc_reg;
  logic          tick;
  logic [7:0]    pressed_reg;
  logic [7:0]    pending_reg;
  logic [7:0]    toggle;
  logic [7:0]    set_bits;
  logic [7:0]    push_clear;
  logic          overflow_reg;
  logic [2:0]    push_idx;
  logic [3:0]    push_data;
  logic          push;
  logic          pop;
  logic          full;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_reg <= 8'hFF;
      sync2_reg <= 8'hFF;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
    end
  end

  assign sample = ~sync2_reg;
  assign tick   = (presc_reg == 16'(TICK_DIV - 1));

  always_ff @(posedge Clock) begin
    if (Reset || tick) presc_reg <= '0;
    else               presc_reg <= presc_reg + 16'd1;
  end

  // Per-button run-length counter of ticks disagreeing with the debounced level.
  for (genvar gi = 0; gi < 8; gi++) begin : g_btn
    logic [3:0] cnt_reg;
    logic       differ;

    assign differ     = sample[gi] ^ pressed_reg[gi];
    assign toggle[gi] = tick && differ && (cnt_reg == 4'(STABLE_CNT - 1));

    always_ff @(posedge Clock) begin
      if (Reset) begin
        cnt_reg <= '0;
      end else if (tick) begin
        if (!differ || toggle[gi]) cnt_reg <= '0;
        else                       cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

`ifdef BUTTON_RELEASE_EVT_EN
  assign set_bits  = toggle;
  assign push_data = {pressed_reg[push_idx], push_idx};
`else
  // Only 0->1 transitions raise an event; a queued press stays a press
  // even if the button has been released again before it is pushed.
  assign set_bits  = toggle & ~pressed_reg;
  assign push_data = {1'b1, push_idx};
`endif

  always_comb begin
    push_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_reg[i]) push_idx = 3'(i);
    end
  end

  assign evt_valid  = (count_reg != '0);
  assign full       = (count_reg == FULL_CNT);
  assign pop        = evt_valid && evt_ready;
  assign push       = (pending_reg != 8'd0) && (!full || pop);
  assign push_clear = push ? (8'd1 << push_idx) : 8'd0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pressed_reg  <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pressed_reg <= pressed_reg ^ toggle;
      // A new event on a bit that is still pending (and not leaving now) replaces the old one.
      pending_reg <= (pending_reg & ~push_clear) | set_bits;
      if ((set_bits & pending_reg & ~push_clear) != 8'd0) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pressed  = pressed_reg;
  assign evt_data = mem[rd_ptr_reg];
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader (TICK_DIV=4, STABLE_CNT=3, FIFO_DEPTH=4).
// Expectations follow BUTTON_RELEASE_EVT_EN when it is defined.
module tb_button_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] btn_n = 8'hFF;
  logic       evt_ready = 1'b0;
  logic [7:0] pressed;
  logic       evt_valid;
  logic [3:0] evt_data;
  logic       overflow;

  int checks = 0;
  int errors = 0;

`ifdef BUTTON_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] btn_n;
    logic       rdy;
    int         cyc;
    logic [7:0] exp_pressed;
    logic       exp_valid;
    logic [3:0] exp_data;
  } vec_t;

  vec_t       vecs[10];
  logic [3:0] got_q[$];
  int         rises;
  int         falls;
  logic       prev0;

  button_reader #(.TICK_DIV(4), .STABLE_CNT(3), .FIFO_DEPTH(4)) dut (
    .Clock(clk), .Reset(rst), .btn_n(btn_n), .pressed(pressed),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  // Pops with ready high and records every entry delivered.
  task automatic drain(input int n);
    evt_ready = 1'b1;
    repeat (n) begin
      if (evt_valid) got_q.push_back(evt_data);
      cycles(1);
    end
    evt_ready = 1'b0;
  endtask

  task automatic monitor(input int n);
    repeat (n) begin
      cycles(1);
      if (pressed[0] !== prev0) begin
        if (pressed[0]) rises++;
        else            falls++;
        prev0 = pressed[0];
      end
      if (evt_valid && evt_ready) got_q.push_back(evt_data);
    end
  endtask

  initial begin
    vecs[0] = '{8'hFF, 1'b0, 2,  8'h00, 1'b0,   4'b0000};
    vecs[1] = '{8'hFE, 1'b0, 24, 8'h01, 1'b1,   4'b1000};
    vecs[2] = '{8'hFE, 1'b1, 1,  8'h01, 1'b0,   4'b0000};
    vecs[3] = '{8'hFF, 1'b0, 24, 8'h00, REL_EN, 4'b0000};
    vecs[4] = '{8'hFF, 1'b1, 1,  8'h00, 1'b0,   4'b0000};
    vecs[5] = '{8'hDD, 1'b0, 24, 8'h22, 1'b1,   4'b1001};
    vecs[6] = '{8'hDD, 1'b1, 1,  8'h22, 1'b1,   4'b1101};
    vecs[7] = '{8'hDD, 1'b1, 1,  8'h22, 1'b0,   4'b0000};
    vecs[8] = '{8'hFF, 1'b0, 24, 8'h00, REL_EN, 4'b0001};
    vecs[9] = '{8'hFF, 1'b1, 2,  8'h00, 1'b0,   4'b0000};

    rst = 1'b1;
    cycles(3);
    chk("reset_pressed", pressed, 8'h00);
    chk("reset_valid", evt_valid, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      btn_n     = vecs[i].btn_n;
      evt_ready = vecs[i].rdy;
      cycles(vecs[i].cyc);
      $display("vec %0d btn_n=%h ready=%b pressed=%h valid=%b data=%b ovf=%b",
               i, btn_n, evt_ready, pressed, evt_valid, evt_data, overflow);
      chk($sformatf("vec%0d_pressed", i), pressed, vecs[i].exp_pressed);
      chk($sformatf("vec%0d_valid", i), evt_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_overflow", i), overflow, 1'b0);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), evt_data, vecs[i].exp_data);
    end
    evt_ready = 1'b0;

    // Held press straight out of reset
    begin
      bit found = 1'b0;
      rst = 1'b1;
      btn_n = 8'hFF;
      cycles(2);
      btn_n = 8'hFB;
      rst = 1'b0;
      for (int k = 0; k < 16 && !found; k++) begin
        cycles(1);
        if (pressed[2] === 1'b1) found = 1'b1;
      end
      $display("seq press_after_reset pressed=%h found=%0d", pressed, found);
      chk("press_within_16", found, 1'b1);
      cycles(2);
      chk("press_valid", evt_valid, 1'b1);
      chk("press_data", evt_data, 4'b1010);
    end

    // Short glitch must not produce an event or a pressed pulse
    btn_n = 8'hFF;
    do_reset();
    evt_ready = 1'b1;
    rises = 0;
    falls = 0;
    prev0 = 1'b0;
    got_q.delete();
    btn_n = 8'hFE; monitor(8);
    btn_n = 8'hFF; monitor(4);
    btn_n = 8'hFE; monitor(40);
    evt_ready = 1'b0;
    $display("seq glitch rises=%0d falls=%0d events=%0d", rises, falls, got_q.size());
    chk("glitch_rises", 8'(rises), 8'd1);
    chk("glitch_falls", 8'(falls), 8'd0);
    chk("glitch_events", 8'(got_q.size()), 8'd1);
    chk("glitch_data", got_q[0], 4'b1000);

    // Six presses with the consumer stalled, then drained in index order
    btn_n = 8'hFF;
    do_reset();
    for (int b = 0; b < 6; b++) begin
      btn_n[b] = 1'b0;
      cycles(20);
    end
    chk("stall_pressed", pressed, 8'h3F);
    chk("stall_valid", evt_valid, 1'b1);
    chk("stall_head", evt_data, 4'b1000);
    got_q.delete();
    drain(20);
    $display("seq stall_drain events=%0d overflow=%b", got_q.size(), overflow);
    chk("stall_count", 8'(got_q.size()), 8'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("stall_evt%0d", k), got_q[k], {1'b1, 3'(k)});
    chk("stall_overflow", overflow, 1'b0);

    // Button 4 changes twice while its event is stuck behind a full FIFO
    btn_n = 8'hFF;
    do_reset();
    btn_n = 8'hF0;
    cycles(24);
    chk("ovf_fill_valid", evt_valid, 1'b1);
    chk("ovf_before", overflow, 1'b0);
    btn_n[4] = 1'b0; cycles(20);
    chk("ovf_after_press", overflow, 1'b0);
    btn_n[4] = 1'b1; cycles(20);
    btn_n[4] = 1'b0; cycles(20);
    $display("seq overflow pressed=%h overflow=%b", pressed, overflow);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_pressed", pressed, 8'h1F);
    rst = 1'b1;
    cycles(1);
    chk("midrst_valid", evt_valid, 1'b0);
    chk("midrst_pressed", pressed, 8'h00);
    chk("midrst_overflow", overflow, 1'b0);
    rst = 1'b0;
    cycles(24);
    chk("held_pressed", pressed, 8'h1F);
    chk("held_valid", evt_valid, 1'b1);
    chk("held_head", evt_data, 4'b1000);

    // Reset with two queued events, then a release of button 3
    btn_n = 8'hFF;
    do_reset();
    btn_n = 8'hF6;
    cycles(24);
    chk("two_valid", evt_valid, 1'b1);
    chk("two_head", evt_data, 4'b1000);
    rst = 1'b1;
    cycles(1);
    chk("two_rst_valid", evt_valid, 1'b0);
    chk("two_rst_pressed", pressed, 8'h00);
    chk("two_rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    cycles(24);
    chk("two_repress", pressed, 8'h09);
    got_q.delete();
    drain(4);
    chk("two_count", 8'(got_q.size()), 8'd2);
    chk("two_evt0", got_q[0], 4'b1000);
    chk("two_evt1", got_q[1], 4'b1011);
    btn_n = 8'hFE;
    cycles(24);
    $display("seq release3 pressed=%h valid=%b data=%b", pressed, evt_valid, evt_data);
    chk("rel3_pressed", pressed, 8'h01);
    chk("rel3_valid", evt_valid, REL_EN);
    if (evt_valid) chk("rel3_data", evt_data, 4'b0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
